dmem_lsu: RTL and testbench

- Load/store unit on the initiator side of the `data_memory` interface.
- Accepts one load or store request at a time from the MEM stage using a valid/ready handshake.
- Translates RISC-V funct3 into the 3-bit `mem_read`/`mem_write` size codes, checks alignment and range, drives exactly one memory access, and returns a registered response using a valid/ready handshake.

---
 rtl/dmem_lsu_if.sv | 54 +++++
 rtl/dmem_lsu.sv | 185 ++++++++++++++++++
 tb/tb_dmem_lsu.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_lsu_if.sv
// -----------------------------------------------------------------------------
// dmem_lsu_if
//   Request/response channel between the MEM stage and the load/store unit.
//
//   Request  (master -> slave): req_valid, req_is_store, req_funct3,
//                               req_addr, req_wdata
//            (slave -> master): req_ready
//   Response (slave -> master): resp_valid, resp_data, resp_fault
//            (master -> slave): resp_ready
//
//   master modport : the MEM stage (issues requests, consumes responses)
//   slave  modport : the LSU (accepts requests, produces responses)
// -----------------------------------------------------------------------------
interface dmem_lsu_if #(
    parameter int XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic            req_is_store;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;

    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic            resp_fault;

    modport master (
        output req_valid,
        output req_is_store,
        output req_funct3,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  resp_valid,
        input  resp_data,
        input  resp_fault,
        output resp_ready
    );

    modport slave (
        input  req_valid,
        input  req_is_store,
        input  req_funct3,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output resp_valid,
        output resp_data,
        output resp_fault,
        input  resp_ready
    );
endinterface

// File: rtl/dmem_lsu.sv
// -----------------------------------------------------------------------------
// dmem_lsu
//   Load/store unit driving the data_memory interface. Takes one load or store
//   at a time, decodes RISC-V funct3 into the memory size codes, checks
//   alignment and range, performs a single one-cycle memory access and returns
//   a registered response.
//
//   Ports
//     clk          clock, rising edge
//     rst          synchronous active-high reset
//     lsu          request/response channel (dmem_lsu_if.slave)
//     mem_read     load size code  (0 idle, 1 B, 2 H, 3 W, 4 D, 5 BU, 6 HU, 7 WU)
//     mem_write    store size code (0 idle, 1 SB, 2 SH, 3 SW, 4 SD)
//     mem_addr     byte address to memory
//     mem_wdata    store data to memory
//     mem_rdata    combinational read data from memory (already extended)
//     fault_count  saturating count of faulted requests
//
//   Timing: accept at edge N, memory access in cycle N+1, response valid in
//   cycle N+2. A faulted request skips the access: response valid in N+1.
// -----------------------------------------------------------------------------
module dmem_lsu #(
    parameter int XLEN        = 64,
    parameter int MEM_BYTES   = 1024,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    dmem_lsu_if.slave       lsu,
    output logic [2:0]      mem_read,
    output logic [2:0]      mem_write,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [15:0]     fault_count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    // Range limit widened by one bit so addr + size is compared without wrap.
    localparam logic [XLEN:0] MEM_LIMIT = (XLEN+1)'(MEM_BYTES);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]      r_state;
    logic            r_is_store;
    logic [2:0]      r_code;        // decoded funct3, doubles as the latched funct3
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_resp_data;
    logic            r_resp_fault;
    logic [15:0]     r_fault_count;

    // ------------------------------------------------------------------
    // Request decode (combinational, from the live request fields)
    // ------------------------------------------------------------------
    logic [2:0]      w_code;
    logic            w_illegal;
    logic [3:0]      w_size;
    logic [2:0]      w_low_bad;
    logic            w_misaligned;
    logic [XLEN:0]   w_end;
    logic            w_out_of_range;
    logic            w_fault;

    always_comb begin
        w_code    = 3'd0;
        w_illegal = 1'b0;
        if (lsu.req_is_store) begin
            // Stores only exist for funct3 000..011.
            if (lsu.req_funct3[2]) begin
                w_illegal = 1'b1;
            end else begin
                w_code = {1'b0, lsu.req_funct3[1:0]} + 3'd1;
            end
        end else begin
            // Loads: 000..110 map to 1..7; 111 has no encoding.
            if (lsu.req_funct3 == 3'b111) begin
                w_illegal = 1'b1;
            end else begin
                w_code = lsu.req_funct3 + 3'd1;
            end
        end
    end

    always_comb begin
        case (w_code)
            3'd1, 3'd5: w_size = 4'd1;
            3'd2, 3'd6: w_size = 4'd2;
            3'd3, 3'd7: w_size = 4'd4;
            3'd4:       w_size = 4'd8;
            default:    w_size = 4'd1;  // illegal request, faults anyway
        endcase
    end

    // Address bit gi must be zero whenever the access is wider than 2**gi
    // bytes; the OR of these is exactly "addr % size != 0" for power-of-two sizes.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_align
            localparam logic [3:0] BIT_WEIGHT = 4'(1 << gi);
            assign w_low_bad[gi] = lsu.req_addr[gi] & (w_size > BIT_WEIGHT);
        end
    endgenerate

    assign w_misaligned   = CHECK_ALIGN ? (|w_low_bad) : 1'b0;
    assign w_end          = {1'b0, lsu.req_addr} + {{(XLEN-3){1'b0}}, w_size};
    assign w_out_of_range = (w_end > MEM_LIMIT);
    assign w_fault        = w_illegal | w_misaligned | w_out_of_range;

    // ------------------------------------------------------------------
    // FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_is_store    <= 1'b0;
            r_code        <= 3'd0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_resp_data   <= '0;
            r_resp_fault  <= 1'b0;
            r_fault_count <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (lsu.req_valid) begin
                        r_is_store   <= lsu.req_is_store;
                        r_code       <= w_code;
                        r_addr       <= lsu.req_addr;
                        r_wdata      <= lsu.req_wdata;
                        r_resp_fault <= w_fault;
                        r_resp_data  <= '0;
                        if (w_fault) begin
                            // Faulted requests never touch memory.
                            r_state <= S_RESP;
                            if (r_fault_count != 16'hFFFF) begin
                                r_fault_count <= r_fault_count + 16'd1;
                            end
                        end else begin
                            r_state <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    r_resp_data <= r_is_store ? '0 : mem_rdata;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    // Always return through IDLE so a new request is taken
                    // only in the cycle after the response handshake.
                    if (lsu.resp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic w_in_access;

    // Qualifying with rst keeps a write from committing on a reset edge.
    assign w_in_access = (r_state == S_ACCESS) && !rst;

    assign mem_read  = (w_in_access && !r_is_store) ? r_code : 3'd0;
    assign mem_write = (w_in_access &&  r_is_store) ? r_code : 3'd0;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign lsu.req_ready  = (r_state == S_IDLE) && !rst;
    assign lsu.resp_valid = (r_state == S_RESP) && !rst;
    assign lsu.resp_data  = r_resp_data;
    assign lsu.resp_fault = r_resp_fault;

    assign fault_count = r_fault_count;

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;

    logic        clk;
    logic        rst;
    logic [2:0]  mem_read;
    logic [2:0]  mem_write;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic [15:0] fault_count;

    dmem_lsu_if #(.XLEN(64)) bus ();

    dmem_lsu #(
        .XLEN        (64),
        .MEM_BYTES   (1024),
        .CHECK_ALIGN (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .lsu         (bus),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .fault_count (fault_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Data memory device: combinational, extended read; byte writes on edge.
    // ------------------------------------------------------------------
    logic [7:0]  dev_mem [0:1023];
    logic [63:0] dev_raw;
    logic        fill_en;
    int          fill_idx;
    logic [7:0]  fill_byte;

    always_comb begin
        dev_raw = '0;
        for (int k = 0; k < 8; k++) begin
            dev_raw[8*k +: 8] = dev_mem[10'(mem_addr[9:0] + 10'(k))];
        end
    end

    always_comb begin
        mem_rdata = '0;
        case (mem_read)
            3'd1: mem_rdata = {{56{dev_raw[7]}},  dev_raw[7:0]};
            3'd2: mem_rdata = {{48{dev_raw[15]}}, dev_raw[15:0]};
            3'd3: mem_rdata = {{32{dev_raw[31]}}, dev_raw[31:0]};
            3'd4: mem_rdata = dev_raw;
            3'd5: mem_rdata = {56'd0, dev_raw[7:0]};
            3'd6: mem_rdata = {48'd0, dev_raw[15:0]};
            3'd7: mem_rdata = {32'd0, dev_raw[31:0]};
            default: mem_rdata = '0;
        endcase
    end

    always @(posedge clk) begin
        if (fill_en) begin
            dev_mem[fill_idx[9:0]] <= fill_byte;
        end else if (mem_write != 3'd0) begin
            for (int k = 0; k < 8; k++) begin
                if (k < (1 << (mem_write - 3'd1))) begin
                    dev_mem[10'(mem_addr[9:0] + 10'(k))] <= mem_wdata[8*k +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model: byte array plus arithmetic from the funct3 rules.
    // ------------------------------------------------------------------
    logic [7:0] ref_mem [0:1023];
    int         n_vec;
    int         n_err;
    int         n_txn;
    int         exp_fc;

    function automatic int ref_size(input logic [2:0] f3);
        return 1 << (f3 % 4);
    endfunction

    function automatic void model_decode(input bit st, input logic [2:0] f3,
                                         input logic [63:0] addr,
                                         output logic [2:0] code, output bit fault);
        bit illegal;
        int sz;
        illegal = st ? (f3 > 3) : (f3 == 7);
        sz      = ref_size(f3);
        code    = illegal ? 3'd0 : f3 + 3'd1;
        fault   = illegal || (addr % 64'(sz) != 0) || (addr > 64'(1024 - sz));
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] addr, input logic [2:0] f3);
        int          sz;
        logic [63:0] v;
        sz = ref_size(f3);
        v  = 64'd0;
        for (int i = 0; i < sz; i++) begin
            v = v + (64'(ref_mem[int'(addr) + i]) << (8 * i));
        end
        // Signed loads narrower than 64 bits: subtract 2**(8*size) when negative.
        if (f3 < 3 && v >= (64'd1 << (8 * sz - 1))) begin
            v = v - (64'd1 << (8 * sz));
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One complete request/response transaction with cycle-level checks.
    task automatic run_req(input bit st, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] wd, input int hold,
                           input logic [2:0] exp_code, input bit exp_fault);
        logic [63:0] exp_data;
        int          guard;
        exp_data = (st || exp_fault) ? 64'd0 : model_load(addr, f3);

        bus.req_valid    = 1'b1;
        bus.req_is_store = st;
        bus.req_funct3   = f3;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        bus.resp_ready   = 1'b0;
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!bus.req_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;           // accept edge
        bus.req_valid = 1'b0;

        if (!exp_fault) begin
            chk("acc_req_ready", bus.req_ready, 1'b0);
            chk("acc_resp_valid", bus.resp_valid, 1'b0);
            chk("acc_mem_read",  mem_read,  st ? 3'd0 : exp_code);
            chk("acc_mem_write", mem_write, st ? exp_code : 3'd0);
            chk("acc_mem_addr",  mem_addr,  addr);
            if (st) chk("acc_mem_wdata", mem_wdata, wd);
            @(posedge clk); #1;
        end

        chk("resp_valid", bus.resp_valid, 1'b1);
        chk("resp_fault", bus.resp_fault, exp_fault);
        chk("resp_data",  bus.resp_data,  exp_data);
        chk("resp_mem_idle", {mem_read, mem_write}, 6'd0);

        for (int h = 0; h < hold; h++) begin
            // A competing request while busy must be ignored.
            bus.req_valid    = 1'b1;
            bus.req_is_store = 1'b0;
            bus.req_funct3   = 3'd3;
            bus.req_addr     = 64'd0;
            @(posedge clk); #1;
            chk("hold_resp_valid", bus.resp_valid, 1'b1);
            chk("hold_resp_data",  bus.resp_data,  exp_data);
            chk("hold_req_ready",  bus.req_ready,  1'b0);
            chk("hold_mem_read",   mem_read,       3'd0);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        chk("post_resp_valid", bus.resp_valid, 1'b0);
        chk("post_req_ready",  bus.req_ready,  1'b1);

        if (st && !exp_fault) begin
            for (int i = 0; i < ref_size(f3); i++) begin
                ref_mem[int'(addr) + i] = 8'((wd >> (8 * i)) & 64'hFF);
            end
        end
        if (exp_fault && exp_fc < 16'hFFFF) exp_fc++;
        chk("fault_count", 64'(fault_count), 64'(exp_fc));
        n_txn++;
        $display("txn %0d %s f3=%0d addr=0x%0h fault=%0d data=0x%0h",
                 n_txn, st ? "st" : "ld", f3, addr, bus.resp_fault, bus.resp_data);
    endtask

    typedef struct {
        bit          st;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wd;
        int          hold;
        logic [2:0]  exp_code;
        bit          exp_fault;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  code;
        bit          fault;
        bit          st;
        logic [2:0]  f3;
        logic [63:0] addr;
        int          sz;

        n_vec = 0; n_err = 0; n_txn = 0; exp_fc = 0;
        bus.req_valid = 1'b0; bus.req_is_store = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0;
        rst = 1'b1;
        fill_en = 1'b1; fill_idx = 0; fill_byte = 8'd0;

        // Load identical random contents into the device and the model.
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = 8'($urandom);
        end
        for (int i = 0; i < 1024; i++) begin
            fill_idx  = i;
            fill_byte = ref_mem[i];
            @(posedge clk); #1;
        end
        fill_en = 1'b0;

        chk("rst_req_ready", bus.req_ready, 1'b0);
        chk("rst_mem_ctrl", {mem_read, mem_write}, 6'd0);
        rst = 1'b0;
        #1;
        chk("reset_req_ready",  bus.req_ready,  1'b1);
        chk("reset_resp_valid", bus.resp_valid, 1'b0);
        chk("reset_resp_fault", bus.resp_fault, 1'b0);
        chk("reset_resp_data",  bus.resp_data,  64'd0);
        chk("reset_mem_addr",   mem_addr,       64'd0);
        chk("reset_mem_wdata",  mem_wdata,      64'd0);
        chk("reset_fault_cnt",  64'(fault_count), 64'd0);

        // Directed vectors: {store, funct3, addr, wdata, hold, code, fault}
        tbl.push_back('{1'b1, 3'd3, 64'd32,   64'h0102030405060708, 0, 3'd4, 1'b0}); // SD
        tbl.push_back('{1'b0, 3'd3, 64'd32,   64'd0,                0, 3'd4, 1'b0}); // LD
        tbl.push_back('{1'b1, 3'd0, 64'd0,    64'hFFFFFFFFFFFFFF80, 0, 3'd1, 1'b0}); // SB
        tbl.push_back('{1'b0, 3'd0, 64'd0,    64'd0,                0, 3'd1, 1'b0}); // LB
        tbl.push_back('{1'b0, 3'd4, 64'd0,    64'd0,                0, 3'd5, 1'b0}); // LBU
        tbl.push_back('{1'b0, 3'd2, 64'd18,   64'd0,                0, 3'd0, 1'b1}); // LW misaligned
        tbl.push_back('{1'b0, 3'd1, 64'd65,   64'd0,                0, 3'd0, 1'b1}); // LH misaligned
        tbl.push_back('{1'b0, 3'd3, 64'd1024, 64'd0,                0, 3'd0, 1'b1}); // LD out of range
        tbl.push_back('{1'b0, 3'd7, 64'd0,    64'd0,                0, 3'd0, 1'b1}); // load 111
        tbl.push_back('{1'b1, 3'd4, 64'd0,    64'd0,                0, 3'd0, 1'b1}); // store 100
        tbl.push_back('{1'b1, 3'd1, 64'd40,   64'h0000000000008001, 0, 3'd2, 1'b0}); // SH
        tbl.push_back('{1'b0, 3'd5, 64'd40,   64'd0,                5, 3'd6, 1'b0}); // LHU, stalled
        tbl.push_back('{1'b0, 3'd3, 64'd1016, 64'd0,                0, 3'd4, 1'b0}); // LD last dword
        tbl.push_back('{1'b0, 3'd0, 64'd1023, 64'd0,                0, 3'd1, 1'b0}); // LB last byte
        tbl.push_back('{1'b0, 3'd2, 64'd1024, 64'd0,                0, 3'd0, 1'b1}); // LW past end
        tbl.push_back('{1'b1, 3'd3, 64'hFFFFFFFFFFFFFFF8, 64'd1,    0, 3'd0, 1'b1}); // SD near wrap
        tbl.push_back('{1'b1, 3'd3, 64'd16,   64'h1122334455667788, 0, 3'd4, 1'b0}); // SD old value
        foreach (tbl[i]) begin
            run_req(tbl[i].st, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].hold,
                    tbl[i].exp_code, tbl[i].exp_fault);
        end

        // Reset in the ACCESS cycle of a SW: no write, response dropped.
        bus.req_valid = 1'b1; bus.req_is_store = 1'b1; bus.req_funct3 = 3'd2;
        bus.req_addr = 64'd16; bus.req_wdata = 64'hDEADBEEF;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("sw_access_write", mem_write, 3'd3);
        rst = 1'b1;
        #1;
        chk("rst_access_write", mem_write, 3'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        exp_fc = 0;
        chk("rst_access_resp_valid", bus.resp_valid, 1'b0);
        chk("rst_access_req_ready",  bus.req_ready,  1'b1);
        chk("rst_access_fault_cnt",  64'(fault_count), 64'd0);
        run_req(1'b0, 3'd2, 64'd16, 64'd0, 0, 3'd3, 1'b0);   // LW sees the old value

        // Reset while a response is held.
        bus.req_valid = 1'b1; bus.req_is_store = 1'b0; bus.req_funct3 = 3'd3;
        bus.req_addr = 64'd32; bus.req_wdata = 64'd0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_resp_valid", bus.resp_valid, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_resp_resp_valid", bus.resp_valid, 1'b0);
        chk("rst_resp_req_ready",  bus.req_ready,  1'b1);

        // Randomized transactions against the model.
        for (int t = 0; t < 150; t++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            sz = ref_size(f3);
            case ($urandom_range(0, 7))
                0: addr = 64'hFFFFFFFFFFFFFFF0 + 64'($urandom_range(0, 15));
                1: addr = 64'(1024 - $urandom_range(0, 16));
                2: addr = 64'($urandom_range(0, 1023));
                default: addr = 64'($urandom_range(0, 1023)) & ~64'(sz - 1);
            endcase
            model_decode(st, f3, addr, code, fault);
            run_req(st, f3, addr, {$urandom, $urandom}, $urandom_range(0, 2), code, fault);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
